// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/dcache request ports plus the shared 32-bit memory port.
interface mem_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BEATS = 4
);
    logic                      i_req;
    logic [ADDR_W-1:0]         i_addr;
    logic [32*LINE_BEATS-1:0]  i_line;
    logic                      i_done;
    logic                      i_busy;
    logic                      d_req;
    logic                      d_we;
    logic [ADDR_W-1:0]         d_addr;
    logic [31:0]               d_wdata;
    logic [3:0]                d_wmask;
    logic [32*LINE_BEATS-1:0]  d_line;
    logic                      d_done;
    logic                      d_busy;
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [31:0]               mem_wdata;
    logic [3:0]                mem_wmask;
    logic [31:0]               mem_rdata;
    logic                      mem_ack;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata, mem_ack,
        output i_line, i_done, i_busy, d_line, d_done, d_busy,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata, mem_ack,
        input  i_line, i_done, i_busy, d_line, d_done, d_busy,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 32-bit memory port between icache line fills and dcache fills/writes.
// Define MEM_ARB_RR_EN to break simultaneous requests round-robin instead of data-first.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BEATS = 4
) (
    input logic           CLK,
    input logic           RST,
    mem_arbiter_if.master bus
);
    localparam int BW = $clog2(LINE_BEATS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BEATS * 4 - 1);

    typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [BW-1:0]     beat;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic              owner_d;
    logic              grant_d;
    logic              fill;
    logic              last;

`ifdef MEM_ARB_RR_EN
    // last_d = 1 when the data port won the most recent grant
    logic last_d;
    assign grant_d = bus.d_req & ~(bus.i_req & last_d);
    always_ff @(posedge CLK or negedge RST)
        if (!RST)
            last_d <= 1'b0;
        else if (state == IDLE && (bus.d_req || bus.i_req))
            last_d <= grant_d;
`else
    assign grant_d = bus.d_req;
`endif

    assign fill = (state == I_FILL) || (state == D_FILL);
    assign last = beat == BW'(LINE_BEATS - 1);

    always_ff @(posedge CLK or negedge RST)
        if (!RST)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:           state_n = grant_d ? (bus.d_we ? D_WRITE : D_FILL) : bus.i_req ? I_FILL : IDLE;
            I_FILL, D_FILL: if (bus.mem_ack && last) state_n = DONE;
            D_WRITE:        if (bus.mem_ack) state_n = DONE;
            default:        state_n = IDLE;
        endcase
    end

    assign bus.mem_req   = fill || (state == D_WRITE);
    assign bus.mem_we    = state == D_WRITE;
    assign bus.mem_addr  = fill ? (addr_q & ~LINE_MASK) | ADDR_W'({beat, 2'b00})
                         : bus.mem_we ? addr_q & ~ADDR_W'(3) : '0;
    assign bus.mem_wdata = bus.mem_we ? wdata_q : '0;
    assign bus.mem_wmask = bus.mem_we ? wmask_q : '0;
    assign bus.i_done    = (state == DONE) && !owner_d;
    assign bus.d_done    = (state == DONE) && owner_d;
    assign bus.i_busy    = bus.i_req && !bus.i_done;
    assign bus.d_busy    = bus.d_req && !bus.d_done;

    // The full requester address is latched; low bits are masked off when forming beats.
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            beat       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            owner_d    <= 1'b0;
            bus.i_line <= '0;
            bus.d_line <= '0;
        end else if (state == IDLE) begin
            beat <= '0;
            if (grant_d) begin
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                wmask_q <= bus.d_wmask;
                owner_d <= 1'b1;
            end else if (bus.i_req) begin
                addr_q  <= bus.i_addr;
                owner_d <= 1'b0;
            end
        end else if (fill && bus.mem_ack) begin
            beat <= beat + BW'(1);
            if (owner_d)
                bus.d_line[{beat, 5'd0} +: 32] <= bus.mem_rdata;
            else
                bus.i_line[{beat, 5'd0} +: 32] <= bus.mem_rdata;
        end
endmodule
